// File: rtl/ftq_pkg.sv
//------------------------------------------------------------------------------
// Module : ftq_pkg
// Brief  : Fetch target queue types, sizing constants and pointer helper.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package ftq_pkg;

  localparam int FTQ_DEPTH     = 8;
  localparam int FTQ_ID_WIDTH  = $clog2(FTQ_DEPTH);
  localparam int FTQ_PTR_WIDTH = FTQ_ID_WIDTH + 1;
  localparam int ADDR_WIDTH    = 32;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] start_pc;
    logic [2:0]            length;
    logic                  is_cross_cacheline;
    logic                  predicted_taken;
  } bpu_ftq_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   start_pc;
    logic [2:0]              length;
    logic                    is_cross_cacheline;
    logic                    predicted_taken;
    logic [FTQ_ID_WIDTH-1:0] ftq_id;
  } ftq_ifu_t;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] start_pc;
    logic                  is_conditional;
    logic                  is_taken;
  } ftq_bpu_meta_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] start_pc;
    logic [2:0]            length;
    logic                  is_cross_cacheline;
    logic                  predicted_taken;
  } ftq_entry_t;

  // Rebuild a full pointer from an entry id: the wrap bit is picked so the
  // result is never behind comm_ptr in circular order.
  function automatic logic [FTQ_PTR_WIDTH-1:0] ftq_redirect_ptr(
    input logic [FTQ_PTR_WIDTH-1:0] comm_ptr,
    input logic [FTQ_ID_WIDTH-1:0]  id
  );
    logic wrap;
    wrap = (id >= comm_ptr[FTQ_ID_WIDTH-1:0]) ? comm_ptr[FTQ_ID_WIDTH]
                                              : ~comm_ptr[FTQ_ID_WIDTH];
    return {wrap, id};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ftq_if.sv
//------------------------------------------------------------------------------
// Module : ftq_if
// Brief  : BPU / IFU / backend handshake bundle of the fetch target queue.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ftq_if;
  import ftq_pkg::*;

  bpu_ftq_t                bpu_i;
  logic                    ftq_full_o;
  logic                    ifu_valid_o;
  logic                    ifu_ready_i;
  ftq_ifu_t                ifu_block_o;
  logic                    commit_valid_i;
  logic                    commit_taken_i;
  logic                    commit_is_conditional_i;
  logic                    redirect_valid_i;
  logic [FTQ_ID_WIDTH-1:0] redirect_ftq_id_i;
  ftq_bpu_meta_t           bpu_meta_o;

  modport master (
    output bpu_i, ifu_ready_i, commit_valid_i, commit_taken_i,
           commit_is_conditional_i, redirect_valid_i, redirect_ftq_id_i,
    input  ftq_full_o, ifu_valid_o, ifu_block_o, bpu_meta_o
  );

  modport slave (
    input  bpu_i, ifu_ready_i, commit_valid_i, commit_taken_i,
           commit_is_conditional_i, redirect_valid_i, redirect_ftq_id_i,
    output ftq_full_o, ifu_valid_o, ifu_block_o, bpu_meta_o
  );

endinterface

`default_nettype wire

// File: rtl/ftq_ptr_ctrl.sv
//------------------------------------------------------------------------------
// Module : ftq_ptr_ctrl
// Brief  : Commit / IFU / BPU pointers of the fetch target queue with wrap,
//          full and pending derivation and redirect rewind.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ftq_ptr_ctrl
  import ftq_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enq_req,
  input  logic                    ifu_ready,
  input  logic                    commit_valid,
  input  logic                    redirect_valid,
  input  logic [FTQ_ID_WIDTH-1:0] redirect_id,
  output logic [FTQ_ID_WIDTH-1:0] bpu_idx,
  output logic [FTQ_ID_WIDTH-1:0] ifu_idx,
  output logic [FTQ_ID_WIDTH-1:0] comm_idx,
  output logic                    full,
  output logic                    ifu_valid,
  output logic                    enq_fire
);

  localparam logic [FTQ_PTR_WIDTH-1:0] c_ptr_one = FTQ_PTR_WIDTH'(1);
  localparam logic [FTQ_PTR_WIDTH-1:0] c_depth   = FTQ_PTR_WIDTH'(FTQ_DEPTH);

  logic [FTQ_PTR_WIDTH-1:0] r_bpu_ptr;
  logic [FTQ_PTR_WIDTH-1:0] r_ifu_ptr;
  logic [FTQ_PTR_WIDTH-1:0] r_comm_ptr;
  logic [FTQ_PTR_WIDTH-1:0] w_count;
  logic [FTQ_PTR_WIDTH-1:0] w_redir_ptr;
  logic [FTQ_PTR_WIDTH-1:0] w_redir_next;
  logic                     w_ifu_fire;

  assign w_count      = r_bpu_ptr - r_comm_ptr;
  assign full         = (w_count == c_depth);
  assign ifu_valid    = (r_ifu_ptr != r_bpu_ptr) & ~redirect_valid;
  assign w_ifu_fire   = ifu_valid & ifu_ready;
  assign enq_fire     = enq_req & ~full & ~redirect_valid;
  assign w_redir_ptr  = ftq_redirect_ptr(r_comm_ptr, redirect_id);
  assign w_redir_next = w_redir_ptr + c_ptr_one;

  assign bpu_idx  = r_bpu_ptr[FTQ_ID_WIDTH-1:0];
  assign ifu_idx  = r_ifu_ptr[FTQ_ID_WIDTH-1:0];
  assign comm_idx = r_comm_ptr[FTQ_ID_WIDTH-1:0];

  // Redirect rewinds both producer-side pointers; commit is independent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bpu_ptr  <= '0;
      r_ifu_ptr  <= '0;
      r_comm_ptr <= '0;
    end else begin
      if (redirect_valid) begin
        r_bpu_ptr <= w_redir_next;
        r_ifu_ptr <= w_redir_next;
      end else begin
        if (enq_fire)   r_bpu_ptr <= r_bpu_ptr + c_ptr_one;
        if (w_ifu_fire) r_ifu_ptr <= r_ifu_ptr + c_ptr_one;
      end
      if (commit_valid) r_comm_ptr <= r_comm_ptr + c_ptr_one;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(commit_valid && (r_comm_ptr == r_ifu_ptr)));
      assert (!(redirect_valid && ((w_redir_ptr - r_comm_ptr) >= w_count)));
    end
  end

endmodule

`default_nettype wire

// File: rtl/ftq.sv
//------------------------------------------------------------------------------
// Module : ftq
// Brief  : Fetch target queue between BPU and IFU, held until backend commit.
//          Optional performance counters enabled by defining FTQ_PERF_CNT_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ftq
  import ftq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  ftq_if.slave        bus,
  output logic [31:0] perf_enq_cnt_o,
  output logic [31:0] perf_full_cyc_o,
  output logic [31:0] perf_redirect_cnt_o
);

  logic [FTQ_ID_WIDTH-1:0] w_bpu_idx;
  logic [FTQ_ID_WIDTH-1:0] w_ifu_idx;
  logic [FTQ_ID_WIDTH-1:0] w_comm_idx;
  logic [FTQ_ID_WIDTH-1:0] w_redir_off;
  logic [FTQ_ID_WIDTH-1:0] w_off;
  logic                    w_full;
  logic                    w_enq_fire;
  logic [FTQ_DEPTH-1:0]    r_entry_valid;
  logic [FTQ_DEPTH-1:0]    w_entry_valid_nxt;
  ftq_entry_t              r_entries [FTQ_DEPTH];
  ftq_bpu_meta_t           r_meta;

  ftq_ptr_ctrl u_ptr_ctrl (
    .clk            (clk),
    .rst            (rst),
    .enq_req        (bus.bpu_i.valid),
    .ifu_ready      (bus.ifu_ready_i),
    .commit_valid   (bus.commit_valid_i),
    .redirect_valid (bus.redirect_valid_i),
    .redirect_id    (bus.redirect_ftq_id_i),
    .bpu_idx        (w_bpu_idx),
    .ifu_idx        (w_ifu_idx),
    .comm_idx       (w_comm_idx),
    .full           (w_full),
    .ifu_valid      (bus.ifu_valid_o),
    .enq_fire       (w_enq_fire)
  );

  assign bus.ftq_full_o = w_full;
  assign bus.bpu_meta_o = r_meta;

  always_comb begin
    bus.ifu_block_o.start_pc           = r_entries[w_ifu_idx].start_pc;
    bus.ifu_block_o.length             = r_entries[w_ifu_idx].length;
    bus.ifu_block_o.is_cross_cacheline = r_entries[w_ifu_idx].is_cross_cacheline;
    bus.ifu_block_o.predicted_taken    = r_entries[w_ifu_idx].predicted_taken;
    bus.ifu_block_o.ftq_id             = w_ifu_idx;
  end

  // Payload storage carries no reset; occupancy lives in r_entry_valid.
  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      r_entries[w_bpu_idx].start_pc           <= bus.bpu_i.start_pc;
      r_entries[w_bpu_idx].length             <= bus.bpu_i.length;
      r_entries[w_bpu_idx].is_cross_cacheline <= bus.bpu_i.is_cross_cacheline;
      r_entries[w_bpu_idx].predicted_taken    <= bus.bpu_i.predicted_taken;
    end
  end

  // Entries whose age offset exceeds the redirecting block's are discarded.
  always_comb begin
    w_redir_off       = bus.redirect_ftq_id_i - w_comm_idx;
    w_off             = '0;
    w_entry_valid_nxt = r_entry_valid;
    for (int i = 0; i < FTQ_DEPTH; i++) begin
      w_off = FTQ_ID_WIDTH'(i) - w_comm_idx;
      if (bus.redirect_valid_i && (w_off > w_redir_off))
        w_entry_valid_nxt[i] = 1'b0;
      if (w_enq_fire && (w_bpu_idx == FTQ_ID_WIDTH'(i)))
        w_entry_valid_nxt[i] = 1'b1;
      if (bus.commit_valid_i && (w_comm_idx == FTQ_ID_WIDTH'(i)))
        w_entry_valid_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_entry_valid <= '0;
      r_meta        <= '0;
    end else begin
      r_entry_valid <= w_entry_valid_nxt;
      if (bus.commit_valid_i) begin
        r_meta.valid          <= 1'b1;
        r_meta.start_pc       <= r_entries[w_comm_idx].start_pc;
        r_meta.is_conditional <= bus.commit_is_conditional_i;
        r_meta.is_taken       <= bus.commit_taken_i;
      end else begin
        r_meta <= '0;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.commit_valid_i && !r_entry_valid[w_comm_idx]));
    end
  end

`ifdef FTQ_PERF_CNT_EN
  localparam logic [31:0] c_sat = 32'hFFFF_FFFF;

  logic [31:0] r_perf_enq;
  logic [31:0] r_perf_full;
  logic [31:0] r_perf_redir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_enq   <= '0;
      r_perf_full  <= '0;
      r_perf_redir <= '0;
    end else begin
      if (w_enq_fire && (r_perf_enq != c_sat))
        r_perf_enq <= r_perf_enq + 32'd1;
      if (w_full && (r_perf_full != c_sat))
        r_perf_full <= r_perf_full + 32'd1;
      if (bus.redirect_valid_i && (r_perf_redir != c_sat))
        r_perf_redir <= r_perf_redir + 32'd1;
    end
  end

  assign perf_enq_cnt_o      = r_perf_enq;
  assign perf_full_cyc_o     = r_perf_full;
  assign perf_redirect_cnt_o = r_perf_redir;
`else
  assign perf_enq_cnt_o      = '0;
  assign perf_full_cyc_o     = '0;
  assign perf_redirect_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ftq.sv
//------------------------------------------------------------------------------
// Module : tb_ftq
// Brief  : Directed and random bench for ftq against a queue-based model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ftq;
  import ftq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] perf_enq, perf_full, perf_redir;

  ftq_if bus();

  ftq dut (
    .clk                 (clk),
    .rst                 (rst),
    .bus                 (bus),
    .perf_enq_cnt_o      (perf_enq),
    .perf_full_cyc_o     (perf_full),
    .perf_redirect_cnt_o (perf_redir)
  );

  always #5 clk = ~clk;

  ftq_ifu_t      q[$];
  int            nf;
  logic [2:0]    next_id;
  ftq_bpu_meta_t exp_meta;
  int            m_enq, m_full, m_redir;
  int            checks = 0;
  int            errors = 0;
  int            meta_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    nf = 0; next_id = '0; exp_meta = '0;
    m_enq = 0; m_full = 0; m_redir = 0;
  endtask

  task automatic chk_perf();
`ifdef FTQ_PERF_CNT_EN
    chk("perf_enq", perf_enq, 32'(m_enq));
    chk("perf_full", perf_full, 32'(m_full));
    chk("perf_redir", perf_redir, 32'(m_redir));
`else
    chk("perf_enq", perf_enq, 32'd0);
    chk("perf_full", perf_full, 32'd0);
    chk("perf_redir", perf_redir, 32'd0);
`endif
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic tick();
    bit efull, evalid;
    ftq_ifu_t e;
    ftq_bpu_meta_t nm;
    int k;
    #1;
    efull  = (q.size() == FTQ_DEPTH);
    evalid = (nf < q.size()) && !bus.redirect_valid_i;
    chk("full", bus.ftq_full_o, efull);
    chk("ifu_valid", bus.ifu_valid_o, evalid);
    if (evalid) chk("ifu_block", bus.ifu_block_o, q[nf]);
    chk("meta", bus.bpu_meta_o, exp_meta);
    @(posedge clk);
    nm = '0;
    if (bus.commit_valid_i) begin
      nm.valid = 1'b1; nm.start_pc = q[0].start_pc;
      nm.is_conditional = bus.commit_is_conditional_i;
      nm.is_taken = bus.commit_taken_i;
    end
    if (efull) m_full++;
    if (bus.redirect_valid_i) begin
      k = -1;
      for (int i = 0; i < q.size(); i++)
        if (q[i].ftq_id == bus.redirect_ftq_id_i) k = i;
      while (q.size() > k + 1) void'(q.pop_back());
      nf = k + 1;
      next_id = bus.redirect_ftq_id_i + 3'd1;
      m_redir++;
    end else begin
      if (evalid && bus.ifu_ready_i) nf++;
      if (bus.bpu_i.valid && !efull) begin
        e.start_pc = bus.bpu_i.start_pc; e.length = bus.bpu_i.length;
        e.is_cross_cacheline = bus.bpu_i.is_cross_cacheline;
        e.predicted_taken = bus.bpu_i.predicted_taken;
        e.ftq_id = next_id;
        q.push_back(e);
        next_id++;
        m_enq++;
      end
    end
    if (bus.commit_valid_i) begin
      void'(q.pop_front());
      nf--;
    end
    exp_meta = nm;
    @(negedge clk);
  endtask

  task automatic drive(input bit bv, input logic [31:0] pc, input logic [2:0] len,
                       input logic [1:0] fl, input bit rdy, input bit cv, input bit ct,
                       input bit cc, input bit rv, input logic [2:0] rid);
    bus.bpu_i.valid = bv; bus.bpu_i.start_pc = pc; bus.bpu_i.length = len;
    bus.bpu_i.is_cross_cacheline = fl[1]; bus.bpu_i.predicted_taken = fl[0];
    bus.ifu_ready_i = rdy; bus.commit_valid_i = cv; bus.commit_taken_i = ct;
    bus.commit_is_conditional_i = cc; bus.redirect_valid_i = rv;
    bus.redirect_ftq_id_i = rid;
    tick();
  endtask

  task automatic idle(input bit rdy, input bit cv);
    drive(1'b0, 32'h0, 3'd0, 2'b00, rdy, cv, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  // Async reset part-way through a low clock phase; outputs must drop at once.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_ifu_valid", bus.ifu_valid_o, 1'b0);
    chk("rst_full", bus.ftq_full_o, 1'b0);
    chk("rst_meta", bus.bpu_meta_o, '0);
    model_clear();
    chk_perf();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    ftq_bpu_meta_t em;
    bus.bpu_i = '0; bus.ifu_ready_i = 0; bus.commit_valid_i = 0;
    bus.commit_taken_i = 0; bus.commit_is_conditional_i = 0;
    bus.redirect_valid_i = 0; bus.redirect_ftq_id_i = '0;
    rst = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ifu_valid", bus.ifu_valid_o, 1'b0);
    chk("reset_full", bus.ftq_full_o, 1'b0);
    chk("reset_meta", bus.bpu_meta_o, '0);
    chk_perf();
    @(negedge clk);
    rst = 1'b0;

    // Single block: visible to the IFU one cycle after enqueue.
    drive(1'b1, 32'h1c00_0000, 3'd4, 2'b00, 1'b1, 0, 0, 0, 0, 3'd0);
    chk("t1_valid", bus.ifu_valid_o, 1'b1);
    chk("t1_pc", bus.ifu_block_o.start_pc, 32'h1c00_0000);
    chk("t1_id", bus.ifu_block_o.ftq_id, 3'd0);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);

    // Fill to full, drop the ninth, free one by commit.
    do_reset();
    for (int i = 0; i < 8; i++)
      drive(1'b1, 32'h1c00_0000 + 32'(i * 16), 3'd4, 2'b01, 1'b0, 0, 0, 0, 0, 3'd0);
    chk("t2_full", bus.ftq_full_o, 1'b1);
    drive(1'b1, 32'h1c00_0100, 3'd4, 2'b10, 1'b0, 0, 0, 0, 0, 3'd0);
    idle(1'b1, 1'b0);
    chk("t2_still_full", bus.ftq_full_o, 1'b1);
    idle(1'b0, 1'b1);
    chk("t2_freed", bus.ftq_full_o, 1'b0);
    idle(1'b0, 1'b0);

    // Streaming: 20 blocks through enqueue, fetch and commit.
    do_reset();
    meta_seen = 0;
    for (int n = 0; n < 24; n++) begin
      drive(n < 20, 32'h1c00_0000 + 32'(n * 16), 3'(n), 2'(n), 1'b1,
            nf > 0, n[0], n[1], 1'b0, 3'd0);
      if (bus.bpu_meta_o.valid) meta_seen++;
    end
    chk("t3_meta_count", 32'(meta_seen), 32'd20);

    // Redirect to id 1 with a competing enqueue.
    do_reset();
    for (int i = 0; i < 5; i++)
      drive(1'b1, 32'h1c00_0000 + 32'(i * 16), 3'd4, 2'b00, 1'b0, 0, 0, 0, 0, 3'd0);
    repeat (3) idle(1'b1, 1'b0);
    drive(1'b1, 32'h2000_0000, 3'd4, 2'b00, 1'b1, 0, 0, 0, 1'b1, 3'd1);
    chk("t4_no_pending", bus.ifu_valid_o, 1'b0);
    drive(1'b1, 32'h2000_0040, 3'd2, 2'b00, 1'b0, 0, 0, 0, 0, 3'd0);
    chk("t4_valid", bus.ifu_valid_o, 1'b1);
    chk("t4_id", bus.ifu_block_o.ftq_id, 3'd2);
    chk("t4_pc", bus.ifu_block_o.start_pc, 32'h2000_0040);

    // Commit entries 0 and 1; the second reports taken conditional.
    idle(1'b0, 1'b1);
    drive(1'b0, 32'h0, 3'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    em.valid = 1'b1; em.start_pc = 32'h1c00_0010;
    em.is_conditional = 1'b1; em.is_taken = 1'b1;
    chk("t5_meta", bus.bpu_meta_o, em);
    idle(1'b0, 1'b0);
    chk("t5_meta_clear", bus.bpu_meta_o.valid, 1'b0);

    // Random traffic.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bit rv;
      logic [2:0] rid;
      rv  = (q.size() > 0) && ($urandom_range(0, 15) == 0);
      rid = (q.size() > 0) ? q[$urandom_range(0, q.size() - 1)].ftq_id : 3'd0;
      drive($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFF0, 3'($urandom),
            2'($urandom), $urandom_range(0, 2) != 0,
            (nf > 0) && ($urandom_range(0, 2) != 0),
            1'($urandom), 1'($urandom), rv, rid);
    end

    // Fill with IFU stalled, then reset mid-stream.
    for (int i = 0; i < 9; i++)
      drive(1'b1, 32'h3000_0000 + 32'(i * 16), 3'd4, 2'b00, 1'b0, 0, 0, 0, 0, 3'd0);
    chk("t6_full_before", bus.ftq_full_o, 1'b1);
    chk("t6_valid_before", bus.ifu_valid_o, 1'b1);
    do_reset();
    idle(1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
